// File: rtl/nmos_bus_arbiter.sv
// nmos_bus_arbiter: round-robin, break-before-make gate arbiter for N nmos pass switches on one bus.
// Define NMOS_ARB_TIMEOUT_EN to build the hold-limit revocation (timeout_o); otherwise timeout_o is 0.
module nmos_bus_arbiter #(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gate_o,
    output logic [$clog2(N)-1:0] owner_o,
    output logic                 bus_idle_o,
    output logic                 timeout_o
);
    localparam int W  = $clog2(N);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_e;

    state_e        state_q;
    logic [N-1:0]  gate_q;
    logic [W-1:0]  owner_q, ptr_q, sel_idx, cand;
    logic [DW-1:0] dead_q;
    logic          sel_vld, dead_last, arb, rel, hold_hit;

    if (N < 2 || N > 16 || DEAD_CYCLES < 1 || MAX_HOLD < 1) begin : g_param_check
        $error("nmos_bus_arbiter: illegal parameter combination");
    end

    // Scan from the farthest candidate down so the one nearest the pointer wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = W'((int'(ptr_q) + i) % N);
            if (req_i[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign dead_last = dead_q == DW'(DEAD_CYCLES - 1);
    assign arb       = state_q == IDLE || (state_q == DEAD && dead_last);
    assign rel       = !req_i[owner_q] || hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            dead_q  <= '0;
        end else if (state_q == GRANT) begin
            if (rel) begin
                state_q <= DEAD;
                gate_q  <= '0;
                dead_q  <= '0;
                ptr_q   <= owner_q == W'(N - 1) ? '0 : owner_q + 1'b1;
            end
        end else if (arb && sel_vld) begin
            state_q <= GRANT;
            gate_q  <= N'(1) << sel_idx;
            owner_q <= sel_idx;
        end else if (arb) begin
            state_q <= IDLE;
        end else begin
            dead_q <= dead_q + 1'b1;
        end
    end

`ifdef NMOS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q;
    logic          timeout_q;

    // hold_q counts completed gate-on cycles; the limit fires at the end of the MAX_HOLD-th one.
    assign hold_hit = state_q == GRANT && req_i[owner_q] && hold_q == HW'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= state_q == GRANT && !rel ? hold_q + 1'b1 : '0;
            timeout_q <= hold_hit;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign hold_hit  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign gate_o     = gate_q;
    assign owner_o    = owner_q;
    assign bus_idle_o = ~|gate_q;
endmodule

// File: tb/tb_nmos_bus_arbiter.sv
// tb_nmos_bus_arbiter: directed self-checking bench for nmos_bus_arbiter (N=4, DEAD_CYCLES=1, MAX_HOLD=4).
module tb_nmos_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_i;
    logic [3:0] gate_o;
    logic [1:0] owner_o;
    logic       bus_idle_o;
    logic       timeout_o;
    int         checks = 0;
    int         errors = 0;

    nmos_bus_arbiter #(.N(4), .DEAD_CYCLES(1), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .gate_o     (gate_o),
        .owner_o    (owner_o),
        .bus_idle_o (bus_idle_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_i = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 4'b1111;
        repeat (3) @(negedge clk);
        checks++; if (gate_o !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b expected 0000", gate_o); end
        checks++; if (bus_idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", bus_idle_o); end
        checks++; if (owner_o !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gate_o !== 4'b0001) begin errors++; $display("FAIL reset_release_gate: got %b expected 0001", gate_o); end
        req_i = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (gate_o !== 4'b0100) begin errors++; $display("FAIL single_gate[%0d]: got %b expected 0100", c, gate_o); end
            checks++; if (owner_o !== 2'd2) begin errors++; $display("FAIL single_owner[%0d]: got %0d expected 2", c, owner_o); end
        end
        req_i = 4'b0000;
        @(negedge clk);
        checks++; if (gate_o !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", gate_o); end
        checks++; if (bus_idle_o !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", bus_idle_o); end
        checks++; if (owner_o !== 2'd2) begin errors++; $display("FAIL single_owner_hold: got %0d expected 2", owner_o); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_owner [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] g, prev;
        int k = 0, hold = 0, gap = 0;
        do_reset();
        req_i = 4'b1111;
        prev  = 4'b0000;
        for (int c = 0; c < 60 && k < 5; c++) begin
            @(negedge clk);
            g = gate_o;
            checks++; if ($countones(g) > 1) begin errors++; $display("FAIL rr_popcount[%0d]: got %b expected at most one bit", c, g); end
            if (g != 4'b0000) begin
                if (prev == 4'b0000) begin
                    checks++; if (owner_o !== exp_owner[k]) begin errors++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", k, owner_o, exp_owner[k]); end
                    checks++; if (g !== 4'b0001 << exp_owner[k]) begin errors++; $display("FAIL rr_gate[%0d]: got %b expected onehot %0d", k, g, exp_owner[k]); end
                    if (k > 0) begin
                        checks++; if (gap !== 1) begin errors++; $display("FAIL rr_gap[%0d]: got %0d expected 1", k, gap); end
                    end
                    k++;
                    hold = 0;
                end else begin
                    checks++; if (g !== prev) begin errors++; $display("FAIL rr_switch[%0d]: got %b expected %b", c, g, prev); end
                end
                hold++;
                if (hold == 3) req_i[owner_o] = 1'b0;
                gap = 0;
            end else begin
                gap++;
                req_i = 4'b1111;
            end
            prev = g;
        end
        checks++; if (k !== 5) begin errors++; $display("FAIL rr_grants: got %0d expected 5", k); end
        req_i = 4'b0000;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        req_i = 4'b0100;
        @(negedge clk);
        req_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        req_i = 4'b0010;
        @(negedge clk);
        checks++; if (gate_o !== 4'b0010) begin errors++; $display("FAIL wrap_gate: got %b expected 0010", gate_o); end
        checks++; if (owner_o !== 2'd1) begin errors++; $display("FAIL wrap_owner: got %0d expected 1", owner_o); end
        req_i = 4'b1001;
        @(negedge clk);
        checks++; if (bus_idle_o !== 1'b1) begin errors++; $display("FAIL wrap_dead: got %b expected 1", bus_idle_o); end
        @(negedge clk);
        checks++; if (gate_o !== 4'b1000) begin errors++; $display("FAIL wrap_priority: got %b expected 1000", gate_o); end
        req_i = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_i = 4'b1000;
        @(negedge clk);
        checks++; if (gate_o !== 4'b1000) begin errors++; $display("FAIL mid_pre_gate: got %b expected 1000", gate_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gate_o !== 4'b0000) begin errors++; $display("FAIL mid_async_gate: got %b expected 0000", gate_o); end
        checks++; if (bus_idle_o !== 1'b1) begin errors++; $display("FAIL mid_async_idle: got %b expected 1", bus_idle_o); end
        checks++; if (owner_o !== 2'd0) begin errors++; $display("FAIL mid_async_owner: got %0d expected 0", owner_o); end
        @(negedge clk);
        req_i = 4'b1001;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gate_o !== 4'b0001) begin errors++; $display("FAIL mid_restart: got %b expected 0001", gate_o); end
        req_i = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        req_i = 4'b0011;
`ifdef NMOS_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (gate_o !== 4'b0001) begin errors++; $display("FAIL to_hold_gate[%0d]: got %b expected 0001", c, gate_o); end
            checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_hold_pulse[%0d]: got %b expected 0", c, timeout_o); end
        end
        @(negedge clk);
        checks++; if (gate_o !== 4'b0000) begin errors++; $display("FAIL to_dead_gate: got %b expected 0000", gate_o); end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout_o); end
        @(negedge clk);
        checks++; if (gate_o !== 4'b0010) begin errors++; $display("FAIL to_next_gate: got %b expected 0010", gate_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b expected 0", timeout_o); end
`else
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++; if (gate_o !== 4'b0001) begin errors++; $display("FAIL nto_gate[%0d]: got %b expected 0001", c, gate_o); end
            checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL nto_pulse[%0d]: got %b expected 0", c, timeout_o); end
        end
`endif
        req_i = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap_skip();
        test_reset_mid_grant();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
